// File: rtl/data_mem_ctrl_if.sv
// CPU-side MEM port bundle: request address/data/control in, load data, stall and error out.
// Latency: none, this is wiring only.
// Backpressure: mem_stall tells the master to hold its request stable.
interface data_mem_ctrl_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_ctrl_signal;   // [4]=load [3]=store [2:1]=size [0]=sign-extend
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        addr_err;

    modport master (
        output mem_addr, mem_wdata, mem_ctrl_signal,
        input  mem_rdata, mem_stall, addr_err
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_ctrl_signal,
        output mem_rdata, mem_stall, addr_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: cpu MEM port to one 32-bit async SRAM, with byte lanes and load extend.
// Latency: WAIT_CYCLES+1 stalled cycles per access; load data valid in the DONE cycle.
// Backpressure: mem_stall holds the CPU; optional posted-write buffer (MEM_WBUF_EN) releases stores early.
module data_mem_ctrl #(
    parameter int WAIT_CYCLES = 2,   // cycles the strobes stay active, >= 1
    parameter int SRAM_AW     = 20   // SRAM word-address width
) (
    input  logic               clk_50M,
    input  logic               reset_btn,
    data_mem_ctrl_if.slave     cpu,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_dout,
    input  logic [31:0]        sram_din,
    output logic               sram_dout_oe,
    output logic [3:0]         sram_be_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] cnt_q;
    logic [31:0]   rdata_q;
    logic          addr_err_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          sext_q;
    logic          load_q;
    logic          stall;

`ifdef MEM_WBUF_EN
    logic          drain_q;   // current ACCESS/DONE is a posted store nobody waits for
`endif

    // Request decode
    logic       is_load, is_store, valid, sext, misaligned, start;
    logic [1:0] size, off;

    assign is_load  = cpu.mem_ctrl_signal[4];
    assign is_store = cpu.mem_ctrl_signal[3];
    assign size     = cpu.mem_ctrl_signal[2:1];
    assign sext     = cpu.mem_ctrl_signal[0];
    assign off      = cpu.mem_addr[1:0];
    assign valid    = is_load ^ is_store;

    // Size 2'b11 is treated like a word everywhere.
    assign misaligned = valid & (((size == 2'b01) & off[0]) | (size[1] & (off != 2'b00)));
    assign start      = (state_q == IDLE) & valid & ~misaligned;

    // Upper byte-address bits beyond the SRAM are ignored.
    generate
        if (SRAM_AW < 30) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^cpu.mem_addr[31:SRAM_AW+2];
        end
    endgenerate

    // Active-low lane enables for the addressed byte/half/word.
    function automatic logic [3:0] calc_be_n(input logic [1:0] sz, input logic [1:0] o);
        logic [3:0] be_n;
        be_n = 4'h0;
        case (sz)
            2'b00:   be_n = ~(4'b0001 << o);
            2'b01:   be_n = o[1] ? 4'b0011 : 4'b1100;
            default: be_n = 4'h0;
        endcase
        return be_n;
    endfunction

    // Store data replicated across lanes so the enabled lane always carries it.
    function automatic logic [31:0] rep_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (sz)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Shift the addressed lane down and extend to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] din, input logic [1:0] sz,
                                            input logic [1:0] o, input logic sx);
        logic [31:0] sh;
        logic [31:0] r;
        sh = din >> {o, 3'b000};
        r  = din;
        case (sz)
            2'b00:   r = {{24{sx & sh[7]}}, sh[7:0]};
            2'b01:   r = {{16{sx & sh[15]}}, sh[15:0]};
            default: r = din;
        endcase
        return r;
    endfunction

    // State register
    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one pass IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stall: the CPU waits until its own access reaches DONE
    always_comb begin
        stall = 1'b0;
`ifdef MEM_WBUF_EN
        case (state_q)
            IDLE:    stall = valid & ~misaligned & ~is_store;
            ACCESS:  stall = valid;
            DONE:    stall = valid & drain_q;
            default: stall = valid;
        endcase
`else
        stall = valid & (state_q != DONE) & ~misaligned;
`endif
    end

    // SRAM strobes, latched request, wait counter, load capture and error pulse
    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            sram_addr    <= '0;
            sram_dout    <= '0;
            sram_dout_oe <= 1'b0;
            sram_be_n    <= 4'hF;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            cnt_q        <= '0;
            rdata_q      <= '0;
            addr_err_q   <= 1'b0;
            off_q        <= 2'b00;
            size_q       <= 2'b00;
            sext_q       <= 1'b0;
            load_q       <= 1'b0;
`ifdef MEM_WBUF_EN
            drain_q      <= 1'b0;
`endif
        end else begin
            // Misaligned requests are only judged when the controller is free to take them.
            addr_err_q <= (state_q == IDLE) & misaligned;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sram_addr    <= cpu.mem_addr[SRAM_AW+1:2];
                        sram_be_n    <= calc_be_n(size, off);
                        sram_dout    <= rep_wdata(size, cpu.mem_wdata);
                        sram_ce_n    <= 1'b0;
                        sram_oe_n    <= ~is_load;
                        sram_we_n    <= ~is_store;
                        sram_dout_oe <= is_store;
                        cnt_q        <= CNT_INIT;
                        off_q        <= off;
                        size_q       <= size;
                        sext_q       <= sext;
                        load_q       <= is_load;
`ifdef MEM_WBUF_EN
                        drain_q      <= is_store;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        // Strobes drop together; read data is sampled while oe_n is still low.
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        if (load_q) begin
                            rdata_q <= extract(sram_din, size_q, off_q, sext_q);
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    // Write data was held one extra cycle past we_n rising.
                    sram_dout_oe <= 1'b0;
                    sram_be_n    <= 4'hF;
`ifdef MEM_WBUF_EN
                    drain_q      <= 1'b0;
`endif
                end
                default: begin
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                end
            endcase
        end
    end

    assign cpu.mem_rdata = rdata_q;
    assign cpu.mem_stall = stall;
    assign cpu.addr_err  = addr_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: behavioural SRAM, vector table of loads/stores, hand sequences for corners.
// Latency: loads checked against a queue of expected results when the stall drops.
// Backpressure: stall cycles counted per request and compared with the expected count.
module tb_data_mem_ctrl;

    logic        clk;
    logic        reset_btn;
    logic [19:0] sram_addr;
    logic [31:0] sram_dout;
    logic [31:0] sram_din;
    logic        sram_dout_oe;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(.WAIT_CYCLES(2), .SRAM_AW(20)) dut (
        .clk_50M      (clk),
        .reset_btn    (reset_btn),
        .cpu          (bus.slave),
        .sram_addr    (sram_addr),
        .sram_dout    (sram_dout),
        .sram_din     (sram_din),
        .sram_dout_oe (sram_dout_oe),
        .sram_be_n    (sram_be_n),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MEM_WBUF_EN
    localparam int STORE_STALL = 0;
`else
    localparam int STORE_STALL = 3;
`endif

    localparam logic [4:0] SW  = 5'b01100;
    localparam logic [4:0] SH  = 5'b01010;
    localparam logic [4:0] SB  = 5'b01000;
    localparam logic [4:0] LW  = 5'b10100;
    localparam logic [4:0] LH  = 5'b10011;
    localparam logic [4:0] LHU = 5'b10010;
    localparam logic [4:0] LB  = 5'b10001;
    localparam logic [4:0] LBU = 5'b10000;

    // Behavioural async SRAM: reads only while selected and output-enabled.
    logic [31:0] mem [0:1023];
    assign sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) mem[sram_addr[9:0]][8*b +: 8] <= sram_dout[8*b +: 8];
            end
        end
    end

    // Strobe monitor: running totals plus the lane/address/data of the latest selected cycle.
    int          ce_total = 0;
    int          we_total = 0;
    logic [3:0]  last_be = 4'hF;
    logic [19:0] last_saddr = '0;
    logic [31:0] last_dout = '0;

    always @(negedge clk) begin
        if (!sram_ce_n) begin
            ce_total   <= ce_total + 1;
            last_be    <= sram_be_n;
            last_saddr <= sram_addr;
            last_dout  <= sram_dout;
        end
        if (!sram_we_n) we_total <= we_total + 1;
    end

    int checks = 0;
    int failures = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_load;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request at the next rising edge, hold it while stalled, check stall count and load data.
    task automatic access(input logic [4:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input int exp_stall);
        int  n;
        bit  done;
        logic [31:0] e;
        @(posedge clk); #1;
        bus.mem_ctrl_signal = ctrl;
        bus.mem_addr        = addr;
        bus.mem_wdata       = wdata;
        if (ctrl[4] && !ctrl[3]) sb_q.push_back(exp_rdata);
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.mem_stall) n++;
            else done = 1'b1;
        end
        if (!done) begin
            failures++;
            checks++;
            $display("FAIL timeout: stall still high after 20 cycles at addr 0x%08h", addr);
        end else begin
            check("stall_cycles", n, exp_stall);
            if (ctrl[4] && !ctrl[3]) begin
                e = sb_q.pop_front();
                check("rdata", bus.mem_rdata, e);
                last_load = e;
            end
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        bus.mem_ctrl_signal = 5'b0;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int ce0, we0;
        bit st;

        vecs.push_back('{SW,          32'h0000_0000, 32'hCAFE_F00D, 32'h0,          4'h0,    32'hCAFE_F00D});
        vecs.push_back('{SW,          32'h0000_0010, 32'h8899_AABB, 32'h0,          4'h0,    32'h8899_AABB});
        vecs.push_back('{LW,          32'h0000_0010, 32'h0,         32'h8899_AABB, 4'h0,    32'h0});
        vecs.push_back('{LB,          32'h0000_0013, 32'h0,         32'hFFFF_FF88, 4'b0111, 32'h0});
        vecs.push_back('{LBU,         32'h0000_0011, 32'h0,         32'h0000_00AA, 4'b1101, 32'h0});
        vecs.push_back('{LH,          32'h0000_0012, 32'h0,         32'hFFFF_8899, 4'b0011, 32'h0});
        vecs.push_back('{LHU,         32'h0000_0010, 32'h0,         32'h0000_AABB, 4'b1100, 32'h0});
        vecs.push_back('{SW,          32'h0000_0100, 32'h1122_3344, 32'h0,          4'h0,    32'h1122_3344});
        vecs.push_back('{SB,          32'h0000_0102, 32'h0000_005A, 32'h0,          4'b1011, 32'h5A5A_5A5A});
        vecs.push_back('{LW,          32'h0000_0100, 32'h0,         32'h115A_3344, 4'h0,    32'h0});
        vecs.push_back('{SW,          32'h0000_0104, 32'h0000_0000, 32'h0,          4'h0,    32'h0});
        vecs.push_back('{SH,          32'h0000_0106, 32'h1234_BEEF, 32'h0,          4'b0011, 32'hBEEF_BEEF});
        vecs.push_back('{LH,          32'h0000_0106, 32'h0,         32'hFFFF_BEEF, 4'b0011, 32'h0});
        vecs.push_back('{LBU,         32'h0000_0107, 32'h0,         32'h0000_00BE, 4'b0111, 32'h0});
        vecs.push_back('{LB,          32'h0000_0104, 32'h0,         32'h0000_0000, 4'b1110, 32'h0});
        vecs.push_back('{LW | 5'b1,   32'h0000_0010, 32'h0,         32'h8899_AABB, 4'h0,    32'h0});

        // Reset state
        reset_btn           = 1'b1;
        bus.mem_ctrl_signal = 5'b0;
        bus.mem_addr        = '0;
        bus.mem_wdata       = '0;
        last_load           = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdata",   bus.mem_rdata, 32'h0);
        check("rst_addr_err", {31'b0, bus.addr_err}, 32'h0);
        check("rst_stall",   {31'b0, bus.mem_stall}, 32'h0);
        check("rst_ce_n",    {31'b0, sram_ce_n}, 32'h1);
        check("rst_oe_n",    {31'b0, sram_oe_n}, 32'h1);
        check("rst_we_n",    {31'b0, sram_we_n}, 32'h1);
        check("rst_be_n",    {28'b0, sram_be_n}, 32'hF);
        check("rst_dout_oe", {31'b0, sram_dout_oe}, 32'h0);
        check("rst_saddr",   {12'b0, sram_addr}, 32'h0);
        check("rst_dout",    sram_dout, 32'h0);
        @(posedge clk); #1;
        reset_btn = 1'b0;

        // Vector table, each request followed by an idle gap so any posted write has drained
        foreach (vecs[k]) begin
            st  = vecs[k].ctrl[3];
            ce0 = ce_total;
            we0 = we_total;
            access(vecs[k].ctrl, vecs[k].addr, vecs[k].wdata, vecs[k].exp_rdata, st ? STORE_STALL : 3);
            idle(4);
            check("be_n",      {28'b0, last_be}, {28'b0, vecs[k].exp_be});
            check("sram_addr", {12'b0, last_saddr}, vecs[k].addr >> 2);
            check("ce_cycles", ce_total - ce0, 32'd2);
            check("we_cycles", we_total - we0, st ? 32'd2 : 32'd0);
            if (st) check("sram_dout", last_dout, vecs[k].exp_dout);
        end

        // Back-to-back loads: second is driven in the IDLE cycle right after DONE
        access(LW, 32'h0000_0010, 32'h0, 32'h8899_AABB, 3);
        access(LW, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 3);
        idle(2);

        // Misaligned word load: error pulse, no stall, no strobes, rdata kept
        ce0 = ce_total;
        @(posedge clk); #1;
        bus.mem_ctrl_signal = LW;
        bus.mem_addr        = 32'h0000_0006;
        @(negedge clk);
        check("mis_lw_stall", {31'b0, bus.mem_stall}, 32'h0);
        @(posedge clk); #1;
        bus.mem_ctrl_signal = 5'b0;
        @(negedge clk);
        check("mis_lw_err", {31'b0, bus.addr_err}, 32'h1);
        @(negedge clk);
        check("mis_lw_err_end", {31'b0, bus.addr_err}, 32'h0);
        check("mis_lw_ce", ce_total - ce0, 32'd0);
        check("mis_lw_rdata", bus.mem_rdata, last_load);

        // Misaligned half store is dropped
        @(posedge clk); #1;
        bus.mem_ctrl_signal = SH;
        bus.mem_addr        = 32'h0000_0003;
        bus.mem_wdata       = 32'h0000_FFFF;
        @(negedge clk);
        check("mis_sh_stall", {31'b0, bus.mem_stall}, 32'h0);
        @(posedge clk); #1;
        bus.mem_ctrl_signal = 5'b0;
        @(negedge clk);
        check("mis_sh_err", {31'b0, bus.addr_err}, 32'h1);
        check("mis_sh_ce", ce_total - ce0, 32'd0);
        access(LW, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 3);
        idle(2);

        // Load and store both set: ignored
        ce0 = ce_total;
        @(posedge clk); #1;
        bus.mem_ctrl_signal = 5'b11100;
        bus.mem_addr        = 32'h0000_0010;
        @(negedge clk);
        check("both_stall", {31'b0, bus.mem_stall}, 32'h0);
        idle(3);
        check("both_ce", ce_total - ce0, 32'd0);
        check("both_err", {31'b0, bus.addr_err}, 32'h0);

        // Reset during the second ACCESS cycle of a word store
        @(posedge clk); #1;
        bus.mem_ctrl_signal = SW;
        bus.mem_addr        = 32'h0000_0020;
        bus.mem_wdata       = 32'h0000_0077;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_btn = 1'b1;
        @(negedge clk);
        check("rst_mid_we_low", {31'b0, sram_we_n}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_we_n",    {31'b0, sram_we_n}, 32'h1);
        check("rst_mid_ce_n",    {31'b0, sram_ce_n}, 32'h1);
        check("rst_mid_dout_oe", {31'b0, sram_dout_oe}, 32'h0);
        check("rst_mid_rdata",   bus.mem_rdata, 32'h0);
        @(posedge clk); #1;
        reset_btn           = 1'b0;
        bus.mem_ctrl_signal = 5'b0;
        @(negedge clk);
        check("rst_mid_stall", {31'b0, bus.mem_stall}, 32'h0);
        access(LW, 32'h0000_0010, 32'h0, 32'h8899_AABB, 3);
        idle(2);

`ifdef MEM_WBUF_EN
        // Posted store followed immediately by a load of the same word
        @(posedge clk); #1;
        bus.mem_ctrl_signal = SW;
        bus.mem_addr        = 32'h0000_0030;
        bus.mem_wdata       = 32'h1357_9BDF;
        @(negedge clk);
        check("wbuf_sw_stall", {31'b0, bus.mem_stall}, 32'h0);
        access(LW, 32'h0000_0030, 32'h0, 32'h1357_9BDF, 6);
        idle(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
